systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Input staging and skew stage that sits directly upstream of the `systolic` array. Holds one N×N operand matrix A (row inputs) and one N×N operand matrix B (column inputs) in local register buffers. On `start`, streams them into the array's `x_flat`/`y_flat` ports with the diagonal skew a systolic matrix multiply needs, and issues the `init` pulse that clears the array's accumulators. It then waits a fixed drain interval and signals `done`, so a downstream reader can sample the array's `z_flat`.

## Interface
- `D_W`, 8, operand element width; matches the array.
- `N`, 2, array dimension; matches the array.
- `DRAIN_CYC`, 2*N, idle cycles after the last feed beat before `done`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `a_wr_en`  in  1  write one row of A.
- `a_wr_row`  in  $clog2(N) (min 1)  row index of A being written.
- `a_wr_data`  in  N*D_W  row data; element k at bits [(k+1)*D_W-1 -: D_W].
- `b_wr_en`  in  1  write one column of B.
- `b_wr_col`  in  $clog2(N) (min 1)  column index of B being written.
- `b_wr_data`  in  N*D_W  column data; element k (= B[k][col]) at bits [(k+1)*D_W-1 -: D_W].
- `start`  in  1  begin a feed/drain run.
- `x_flat`  out  N*D_W  to array rows; lane i at bits [(i+1)*D_W-1 -: D_W].
- `y_flat`  out  N*D_W  to array columns; lane j at the same slice layout.
- `init`  out  1  one-cycle accumulator-clear pulse to the array.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse; array outputs are final.

## Operation
- Reset: all A/B buffer entries are 0. `x_flat`, `y_flat`, `init`, `busy` and `done` are all 0. FSM is in IDLE.
- Writes: accepted only when `busy`=0; ignored while busy. A and B writes in the same cycle are independent. A write to an out-of-range index (possible when N is not a power of 2) is ignored.
- FSM states:
  - IDLE: `start`=1 → FEED; the counter t is cleared to 0.
  - FEED: lasts 2N-1 cycles, t = 0..2N-2. On t=2N-2 → DRAIN.
  - DRAIN: lasts DRAIN_CYC cycles, then → DONE. If DRAIN_CYC=0, FEED goes directly to DONE.
  - DONE: lasts 1 cycle, then → IDLE. `start` sampled in DONE → FEED, giving back-to-back runs.
- Skew rule in FEED beat t:
  - x lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - y lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
- `init`=1 only during FEED beat t=0.
- In DRAIN, DONE and IDLE, `x_flat` and `y_flat` are 0.
- `start` while `busy`=1 is ignored; the run is not restarted.
- Write and `start` in the same cycle: the write lands first, and FEED uses the new data.
- Reset asserted mid-run: all outputs go to 0 immediately (asynchronous), buffers clear, FSM returns to IDLE, and no `done` is issued.
- Data is passed through unsigned and unmodified; the block does no arithmetic on it.

## Timing
- All outputs are registered. `start` sampled at edge c → FEED beat t appears on the outputs in cycle c+1+t.
- `init`: high during cycle c+1 only.
- `busy`: high from cycle c+1 through the last DRAIN cycle, c+2N-1+DRAIN_CYC. Low in the DONE cycle.
- `done`: high for the single cycle c+2N+DRAIN_CYC.
- Start-to-done latency: 2N+DRAIN_CYC cycles.
- Minimum start-to-start period: 2N+DRAIN_CYC cycles, achieved by asserting `start` in the DONE cycle.
- Counter width: $clog2(2N-1+DRAIN_CYC)+1; the counter must not wrap within a run.

## Test plan
- Reset values: hold `rst`=0 for 3 cycles, then release → `x_flat`, `y_flat`, `init`, `busy`, `done` all 0. A `start` with no writes streams only zeros and still gives `done` at c+8 (N=2, DRAIN_CYC=4).
- Basic skew, N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]], `start` at c.
  - c+1: x lanes (1,0), y lanes (5,0), `init`=1.
  - c+2: x (2,3), y (7,6).
  - c+3: x (0,4), y (0,8).
  - c+4..c+7: all zero; `done` at c+8.
- Busy protection: write A row0 = (9,9) and pulse `start` during c+2 → streamed values are unchanged from the basic case and `done` stays at c+8.
- Back-to-back: assert `start` in the DONE cycle with new data A=I, B=[[1,2],[3,4]] → `init` re-pulses the next cycle. Beats are x (1,0)/(0,0)/(0,1) and y (1,0)/(3,2)/(0,4).
- Reset mid-run: drop `rst` during beat t=1 → outputs 0 in the same cycle. After release, the FSM is in IDLE and no `done` pulse appears.
- Integration with the array, N=2, D_W=8: after `done`, `z_flat` = (19,22,43,50) in order z[0][0], z[0][1], z[1][0], z[1][1] for the basic-skew matrices.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: holds one N x N A matrix and one N x N B matrix, then on
// start streams them diagonally skewed into a systolic array, pulses init on
// the first beat, waits a drain interval and pulses done.
module systolic_feeder #(
  parameter int D_W       = 8,
  parameter int N         = 2,
  parameter int DRAIN_CYC = 2 * N,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_wr_en,
  input  logic [IW-1:0]    a_wr_row,
  input  logic [N*D_W-1:0] a_wr_data,
  input  logic             b_wr_en,
  input  logic [IW-1:0]    b_wr_col,
  input  logic [N*D_W-1:0] b_wr_data,
  input  logic             start,
  output logic [N*D_W-1:0] x_flat,
  output logic [N*D_W-1:0] y_flat,
  output logic             init,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(2 * N - 1 + DRAIN_CYC) + 1;
  localparam logic [CW-1:0] LAST_FEED  = CW'(2 * N - 2);
  localparam logic [CW-1:0] LAST_DRAIN = CW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  // a_*[row][k] holds A[row][k]; b_*[k][col] holds B[k][col].
  logic [D_W-1:0] a_q [N][N];
  logic [D_W-1:0] a_d [N][N];
  logic [D_W-1:0] b_q [N][N];
  logic [D_W-1:0] b_d [N][N];

  state_t         state_q, state_d;
  logic [CW-1:0]  t_q, t_d;
  logic [N*D_W-1:0] x_q, x_d, y_q, y_d;
  logic           init_q, init_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Buffer writes: one A row and one B column per cycle, only while idle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_d = a_q;
    b_d = b_q;
    if (!busy_q && a_wr_en) begin
      for (int r = 0; r < N; r++) begin
        if (int'(a_wr_row) == r) begin
          for (int k = 0; k < N; k++) a_d[r][k] = a_wr_data[k*D_W +: D_W];
        end
      end
    end
    if (!busy_q && b_wr_en) begin
      for (int c = 0; c < N; c++) begin
        if (int'(b_wr_col) == c) begin
          for (int k = 0; k < N; k++) b_d[k][c] = b_wr_data[k*D_W +: D_W];
        end
      end
    end
  end

  // Next-state logic and beat counter.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          t_d     = '0;
        end
      end
      S_FEED: begin
        if (t_q == LAST_FEED) begin
          state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (t_q == LAST_DRAIN) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_FEED;
          t_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Registered outputs: computed from the next state and the post-write
  // buffers, so a write in the same cycle as start is already visible.
  always_comb begin
    x_d    = '0;
    y_d    = '0;
    init_d = (state_d == S_FEED) && (t_d == '0);
    busy_d = (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    if (state_d == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_d) == i + k) begin
            x_d[i*D_W +: D_W] = a_d[i][k];
            y_d[i*D_W +: D_W] = b_d[k][i];
          end
        end
      end
    end
  end

  // State, counter, buffers and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the operand buffers are small register arrays that must read as
      // zero after reset, so they are cleared here rather than left as a RAM.
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < N; k++) begin
          a_q[r][k] <= '0;
          b_q[r][k] <= '0;
        end
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      t_q     <= t_d;
      x_q     <= x_d;
      y_q     <= y_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign x_flat = x_q;
  assign y_flat = y_q;
  assign init   = init_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder (N=2, D_W=8, DRAIN_CYC=4): table-driven runs with a
// per-cycle scoreboard, hand-written corner sequences, and a small behavioural
// systolic array that accumulates the streamed operands.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_wr_en, b_wr_en, start;
  logic [0:0]  a_wr_row, b_wr_col;
  logic [15:0] a_wr_data, b_wr_data;
  logic [15:0] x_flat, y_flat;
  logic        init, busy, done;

  systolic_feeder #(.D_W(8), .N(2), .DRAIN_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_col(b_wr_col), .b_wr_data(b_wr_data),
    .start(start),
    .x_flat(x_flat), .y_flat(y_flat), .init(init), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef logic [1:0][1:0][7:0] mat_t;   // m[row][col]
  typedef logic [2:0][15:0]     beats_t; // three FEED beats, lane 0 in low byte

  typedef struct packed {
    mat_t   a;
    mat_t   b;
    beats_t ex;
    beats_t ey;
  } vec_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        init;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t cexp;
  int   n_total = 0;
  int   n_bad   = 0;
  mat_t ma, mb;   // contents the bench believes the DUT buffers hold
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, wanted %0d", name, $time, act, req);
    end
  endtask

  function automatic mat_t mat(input logic [7:0] m00, m01, m10, m11);
    mat_t m;
    m[0][0] = m00; m[0][1] = m01; m[1][0] = m10; m[1][1] = m11;
    return m;
  endfunction

  function automatic logic [15:0] ln(input logic [7:0] l0, input logic [7:0] l1);
    return {l1, l0};
  endfunction

  function automatic beats_t bt(input logic [15:0] b0, b1, b2);
    beats_t b;
    b[0] = b0; b[1] = b1; b[2] = b2;
    return b;
  endfunction

  // Behavioural 2x2 output-stationary array: x moves right, y moves down.
  logic [7:0]  xr [2][2];
  logic [7:0]  yr [2][2];
  logic [7:0]  xin [2][2];
  logic [7:0]  yin [2][2];
  logic [31:0] acc [2][2];

  always_comb begin
    xin[0][0] = x_flat[7:0];  xin[1][0] = x_flat[15:8];
    xin[0][1] = xr[0][0];     xin[1][1] = xr[1][0];
    yin[0][0] = y_flat[7:0];  yin[0][1] = y_flat[15:8];
    yin[1][0] = yr[0][0];     yin[1][1] = yr[0][1];
  end

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!rst) begin
          xr[i][j]  <= '0;
          yr[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          xr[i][j]  <= xin[i][j];
          yr[i][j]  <= yin[i][j];
          acc[i][j] <= (init ? 32'd0 : acc[i][j]) + 32'(xin[i][j]) * 32'(yin[i][j]);
        end
      end
    end
  end

  // Scoreboard checker: one record per cycle; an empty queue means idle zeros.
  always @(posedge clk) begin
    #1;
    cexp = '0;
    if (exp_q.size() > 0) cexp = exp_q.pop_front();
    check("x_flat", 32'(x_flat), 32'(cexp.x));
    check("y_flat", 32'(y_flat), 32'(cexp.y));
    check("init",   32'(init),   32'(cexp.init));
    check("busy",   32'(busy),   32'(cexp.busy));
    check("done",   32'(done),   32'(cexp.done));
  end

  task automatic set_in(input logic st, input logic aen, input logic arow, input logic [15:0] ad,
                        input logic ben, input logic bcol, input logic [15:0] bd);
    start = st;
    a_wr_en = aen; a_wr_row = arow; a_wr_data = ad;
    b_wr_en = ben; b_wr_col = bcol; b_wr_data = bd;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic push_run(input beats_t ex, input beats_t ey);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      e = '0;
      if (r < 3) begin
        e.x = ex[r];
        e.y = ey[r];
      end
      e.init = (r == 0);
      e.busy = (r < 7);
      e.done = (r == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_z();
    logic [31:0] want;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        want = 0;
        for (int k = 0; k < 2; k++) want += 32'(ma[i][k]) * 32'(mb[k][j]);
        check($sformatf("z[%0d][%0d]", i, j), acc[i][j], want);
      end
    end
  endtask

  task automatic load(input mat_t a, input mat_t b);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      set_in(1'b0, 1'b1, r[0], a[r], 1'b1, r[0], {b[1][r], b[0][r]});
    end
    ma = a;
    mb = b;
  endtask

  // Called at the negedge where start was driven; returns in the DONE cycle.
  task automatic finish_run(input beats_t ex, input beats_t ey, input bit inject);
    push_run(ex, ey);
    for (int n = 1; n < 8; n++) begin
      @(negedge clk);
      idle_in();
      if (inject && n == 2) set_in(1'b1, 1'b1, 1'b0, ln(8'd9, 8'd9), 1'b0, 1'b0, 16'h0);
    end
    @(negedge clk);
    idle_in();
    check_z();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " x_flat"}, 32'(x_flat), 32'd0);
    check({tag, " y_flat"}, 32'(y_flat), 32'd0);
    check({tag, " init"},   32'(init),   32'd0);
    check({tag, " busy"},   32'(busy),   32'd0);
    check({tag, " done"},   32'(done),   32'd0);
  endtask

  beats_t zero_b;

  initial begin
    vecs[0].a  = mat(1, 2, 3, 4);
    vecs[0].b  = mat(5, 6, 7, 8);
    vecs[0].ex = bt(ln(1, 0), ln(2, 3), ln(0, 4));
    vecs[0].ey = bt(ln(5, 0), ln(7, 6), ln(0, 8));
    vecs[1].a  = mat(1, 0, 0, 1);
    vecs[1].b  = mat(1, 2, 3, 4);
    vecs[1].ex = bt(ln(1, 0), ln(0, 0), ln(0, 1));
    vecs[1].ey = bt(ln(1, 0), ln(3, 2), ln(0, 4));
    vecs[2].a  = mat(255, 255, 255, 255);
    vecs[2].b  = mat(255, 255, 255, 255);
    vecs[2].ex = bt(ln(255, 0), ln(255, 255), ln(0, 255));
    vecs[2].ey = bt(ln(255, 0), ln(255, 255), ln(0, 255));
    vecs[3].a  = mat(10, 20, 30, 40);
    vecs[3].b  = mat(128, 1, 2, 127);
    vecs[3].ex = bt(ln(10, 0), ln(20, 30), ln(0, 40));
    vecs[3].ey = bt(ln(128, 0), ln(2, 1), ln(0, 127));
    zero_b = '0;
    ma = '0;
    mb = '0;

    // Reset for three cycles, then check every output is zero.
    rst = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset");

    // Start with empty buffers: only zeros stream, done still at c+8.
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    finish_run(zero_b, zero_b, 1'b0);

    // Table-driven runs.
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].a, vecs[v].b);
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      finish_run(vecs[v].ex, vecs[v].ey, 1'b0);
      repeat (2) @(negedge clk);
    end

    // Busy protection: write and start during beat 1 must be ignored.
    load(vecs[0].a, vecs[0].b);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    finish_run(vecs[0].ex, vecs[0].ey, 1'b1);

    // Back-to-back: in the DONE cycle write A row0=(1,0), B col0=(1,3) and start.
    set_in(1'b1, 1'b1, 1'b0, ln(1, 0), 1'b1, 1'b0, ln(1, 3));
    ma[0][0] = 8'd1; ma[0][1] = 8'd0;
    mb[0][0] = 8'd1; mb[1][0] = 8'd3;
    finish_run(bt(ln(1, 0), ln(0, 3), ln(0, 4)), bt(ln(1, 0), ln(3, 6), ln(0, 8)), 1'b0);
    repeat (2) @(negedge clk);

    // Reset mid-run during beat 1: outputs clear at once, no done afterwards.
    load(vecs[0].a, vecs[0].b);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    push_run(vecs[0].ex, vecs[0].ey);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    ma = '0;
    mb = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Buffers were cleared by the reset: a fresh run streams zeros.
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    finish_run(zero_b, zero_b, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
